core_rvfi_rob: RTL
==================

# core_rvfi_rob

Parametrised RVFI retirement buffer, successor to the single-slot RVFI tracer. Instructions enter at commit with their tracking data and receive a tag. Register writeback and memory read data arrive later, in any order, addressed by that tag. Up to NRET completed head entries are emitted per cycle as in-order, NRET-lane RVFI packets with a monotonic `rvfi_order`. Built only under `ifdef RVFI`.

## Interface
- XLEN, 64, data/address width
- ILEN, 32, instruction width
- NRET, 2, RVFI retire lanes per cycle (1..4)
- DEPTH, 8, buffer entries (power of two, ≥ NRET)
- TW, $clog2(DEPTH), tag width
- g_clk  in  1  clock; all state updates on posedge
- g_reset  in  1  reset; synchronous, active-high
- a_valid / a_ready  in/out  1  allocate handshake; transfer when both high
- a_tag  out  TW  tag given to the allocating instruction (current tail index)
- a_insn, a_pc_rdata, a_pc_wdata, a_mode, a_trap, a_intr  in  ILEN/XLEN/XLEN/2/1/1  static record fields
- a_rs1_addr, a_rs2_addr, a_rs1_rdata, a_rs2_rdata  in  5/5/XLEN/XLEN  source operands
- a_rd_pend, a_rd_addr  in  1/5  rd write outstanding; destination
- a_mem_pend, a_mem_addr, a_mem_rmask, a_mem_wmask, a_mem_wdata  in  1/XLEN/XLEN/8/XLEN/8/XLEN  memory read outstanding; request fields
- w_valid, w_tag, w_rd_wdata  in  1/TW/XLEN  rd writeback
- m_valid, m_tag, m_rdata  in  1/TW/XLEN  memory read response
- rvfi_valid  out  NRET  per-lane valid; always contiguous from lane 0
- rvfi_order  out  NRET*64  retirement index per lane
- rvfi_insn … rvfi_mem_wdata, rvfi_mode  out  NRET*field  standard RVFI fields, lane-packed
- rvfi_halt  out  1  tied 0
- err  out  1  sticky protocol-error flag

## Operation
- Circular buffer with `head` and `tail` pointers, each TW+1 bits; the MSB is the wrap bit.
- full = (head ^ tail) == {1'b1, 0…}; empty = head == tail.
- a_ready = !full. It is not relieved by a same-cycle retire.
- Allocation writes the entry at tail[TW-1:0]. The entry's pend_rd and pend_mem are copied from a_rd_pend and a_mem_pend.
- w_valid: writes rd_wdata into the tagged entry and clears pend_rd.
- m_valid: writes mem_rdata into the tagged entry and clears pend_mem.
- w and m on the same tag in the same cycle are legal; both apply.
- Writeback to an entry that is unallocated or not pending sets err. The entry is left unchanged.
- Entry complete = allocated && !pend_rd && !pend_mem.
- Retire count k = length of the run of consecutive complete entries starting at head, capped at NRET.
- Lanes 0..k-1 are loaded from head..head+k-1. head advances by k.
- Order counter: lane i gets order+i; order += k.
- rd normalisation: rvfi_rd_addr = 0 if the entry never had an rd. rvfi_rd_wdata = 0 if rd_addr == 0.
- rvfi_mem_rdata = 0 for entries with no memory read.
- When k = 0, rvfi_valid = 0 and the data outputs hold their previous values.

## Timing
- All outputs are registered.
- Reset values: rvfi_valid = 0, every rvfi_* data field = 0, order = 0, head = tail = 0, all entries unallocated, err = 0. a_ready = 1 the cycle after reset.
- Allocation with no pending fields at edge t: rvfi_valid is asserted after edge t+1 (latency 2).
- Last pending writeback at edge t: the entry retires after edge t+1, provided it is at head.
- Older incomplete entries block younger complete entries (no out-of-order retire).
- Full buffer with simultaneous retire: the allocation is still refused that cycle. a_ready rises the following cycle.
- Pointer wrap is transparent. order is 64-bit and wraps modulo 2^64.
- g_reset mid-operation drops all in-flight entries. Writebacks arriving in the reset cycle are ignored.

## Structure
- Package core_rvfi_pkg holds:
  - rvfi_rec_t struct (all per-entry fields plus pend_rd, pend_mem, alloc);
  - the XLEN/ILEN defaults;
  - the RVFI lane-field width constants.
- Sub-module core_rvfi_retire_sel:
  - combinational;
  - takes the NRET head-window complete bits;
  - returns k and lane enables.

## Test plan
- Single instruction, no pending fields, pc 0x1000: rvfi_valid = 2'b01 two cycles after allocation, order = 0, rd_wdata = 0.
- Load to x5 with rd and mem pending; m_rdata = 0xAA issued before w_rd_wdata = 0xAA: retires one cycle after the w write, mem_rdata = 0xAA, rd_addr = 5.
- Tags 0,1,2 allocated, tags 1 and 2 completed first, tag 0 last: no retire until tag 0 completes. Then lanes retire tags 0 and 1 (orders 0 and 1), next cycle tag 2 (order 2).
- Fill DEPTH = 8 entries: a_ready = 0. One retire frees a slot and a_ready = 1 the next cycle. After 20 allocations tags wrap 7→0 correctly.
- Writeback to an unallocated tag: err = 1 and stays set. Buffer contents are unaffected.
- Assert g_reset with 5 entries in flight: the next cycle rvfi_valid = 0 and a_ready = 1. The next retire has order 0.

Source files
------------

// File: rtl/core_rvfi_pkg.sv
// core_rvfi_pkg: shared widths and record types for the RVFI retirement buffer
package core_rvfi_pkg;

    localparam int XLEN_DEF = 64;
    localparam int ILEN_DEF = 32;
    localparam int ORDER_W  = 64;
    localparam int MODE_W   = 2;
    localparam int REG_W    = 5;
    localparam int MASK_W   = XLEN_DEF / 8;

    typedef struct packed {
        logic [ILEN_DEF-1:0] insn;
        logic                trap;
        logic                intr;
        logic [MODE_W-1:0]   mode;
        logic [XLEN_DEF-1:0] pc_rdata;
        logic [XLEN_DEF-1:0] pc_wdata;
        logic [REG_W-1:0]    rs1_addr;
        logic [REG_W-1:0]    rs2_addr;
        logic [XLEN_DEF-1:0] rs1_rdata;
        logic [XLEN_DEF-1:0] rs2_rdata;
        logic [REG_W-1:0]    rd_addr;
        logic [XLEN_DEF-1:0] rd_wdata;
        logic [XLEN_DEF-1:0] mem_addr;
        logic [MASK_W-1:0]   mem_rmask;
        logic [MASK_W-1:0]   mem_wmask;
        logic [XLEN_DEF-1:0] mem_rdata;
        logic [XLEN_DEF-1:0] mem_wdata;
    } rvfi_out_t;

    typedef struct packed {
        rvfi_out_t d;
        logic      pend_rd;
        logic      pend_mem;
        logic      alloc;
    } rvfi_rec_t;

endpackage

// File: rtl/core_rvfi_retire_sel.sv
// core_rvfi_retire_sel: picks the run of complete entries at the head window
module core_rvfi_retire_sel #(
    parameter int NRET = 2,
    parameter int KW   = $clog2(NRET + 1)
) (
    input  logic [NRET-1:0] i_done,
    output logic [KW-1:0]   o_k,
    output logic [NRET-1:0] o_en
);

    logic w_run;

    // a lane is enabled only while every older lane in the window is complete
    always_comb begin
        w_run = 1'b1;
        o_en  = '0;
        o_k   = '0;
        for (int i = 0; i < NRET; i++) begin
            w_run   = w_run & i_done[i];
            o_en[i] = w_run;
            o_k     = o_k + KW'(w_run);
        end
    end

endmodule

// File: rtl/core_rvfi_rob.sv
// core_rvfi_rob: tagged reorder buffer that emits in-order multi-lane RVFI packets
module core_rvfi_rob
    import core_rvfi_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int ILEN  = ILEN_DEF,
    parameter int NRET  = 2,
    parameter int DEPTH = 8,
    parameter int TW    = $clog2(DEPTH)
) (
    input  logic                     g_clk,
    input  logic                     g_reset,
    input  logic                     a_valid,
    output logic                     a_ready,
    output logic [TW-1:0]            a_tag,
    input  logic [ILEN-1:0]          a_insn,
    input  logic [XLEN-1:0]          a_pc_rdata,
    input  logic [XLEN-1:0]          a_pc_wdata,
    input  logic [1:0]               a_mode,
    input  logic                     a_trap,
    input  logic                     a_intr,
    input  logic [4:0]               a_rs1_addr,
    input  logic [4:0]               a_rs2_addr,
    input  logic [XLEN-1:0]          a_rs1_rdata,
    input  logic [XLEN-1:0]          a_rs2_rdata,
    input  logic                     a_rd_pend,
    input  logic [4:0]               a_rd_addr,
    input  logic                     a_mem_pend,
    input  logic [XLEN-1:0]          a_mem_addr,
    input  logic [XLEN/8-1:0]        a_mem_rmask,
    input  logic [XLEN/8-1:0]        a_mem_wmask,
    input  logic [XLEN-1:0]          a_mem_wdata,
    input  logic                     w_valid,
    input  logic [TW-1:0]            w_tag,
    input  logic [XLEN-1:0]          w_rd_wdata,
    input  logic                     m_valid,
    input  logic [TW-1:0]            m_tag,
    input  logic [XLEN-1:0]          m_rdata,
    output logic [NRET-1:0]          rvfi_valid,
    output logic [NRET*64-1:0]       rvfi_order,
    output logic [NRET*ILEN-1:0]     rvfi_insn,
    output logic [NRET-1:0]          rvfi_trap,
    output logic [NRET-1:0]          rvfi_intr,
    output logic [NRET*2-1:0]        rvfi_mode,
    output logic [NRET*5-1:0]        rvfi_rs1_addr,
    output logic [NRET*5-1:0]        rvfi_rs2_addr,
    output logic [NRET*XLEN-1:0]     rvfi_rs1_rdata,
    output logic [NRET*XLEN-1:0]     rvfi_rs2_rdata,
    output logic [NRET*5-1:0]        rvfi_rd_addr,
    output logic [NRET*XLEN-1:0]     rvfi_rd_wdata,
    output logic [NRET*XLEN-1:0]     rvfi_pc_rdata,
    output logic [NRET*XLEN-1:0]     rvfi_pc_wdata,
    output logic [NRET*XLEN-1:0]     rvfi_mem_addr,
    output logic [NRET*XLEN/8-1:0]   rvfi_mem_rmask,
    output logic [NRET*XLEN/8-1:0]   rvfi_mem_wmask,
    output logic [NRET*XLEN-1:0]     rvfi_mem_rdata,
    output logic [NRET*XLEN-1:0]     rvfi_mem_wdata,
    output logic                     rvfi_halt,
    output logic                     err
);

    localparam int KW = $clog2(NRET + 1);

    rvfi_rec_t          r_ent [DEPTH];
    rvfi_out_t          r_lane [NRET];
    logic [ORDER_W-1:0] r_ord [NRET];
    logic [ORDER_W-1:0] r_order;
    logic [TW:0]        r_head;
    logic [TW:0]        r_tail;
    logic [NRET-1:0]    r_valid;
    logic               r_err;
    logic               w_full;
    logic               w_alloc;
    logic               w_werr;
    logic               w_merr;
    logic [TW-1:0]      w_idx [NRET];
    rvfi_out_t          w_norm [NRET];
    logic [NRET-1:0]    w_done;
    logic [NRET-1:0]    w_en;
    logic [KW-1:0]      w_k;
    rvfi_rec_t          w_new;

    assign w_full    = (r_head ^ r_tail) == {1'b1, {TW{1'b0}}};
    assign a_ready   = !w_full;
    assign a_tag     = r_tail[TW-1:0];
    assign w_alloc   = a_valid && !w_full;
    assign w_werr    = w_valid && !(r_ent[w_tag].alloc && r_ent[w_tag].pend_rd);
    assign w_merr    = m_valid && !(r_ent[m_tag].alloc && r_ent[m_tag].pend_mem);
    assign rvfi_halt = 1'b0;
    assign rvfi_valid = r_valid;
    assign err       = r_err;

    // head window completeness and rd normalisation of the candidate lanes
    always_comb begin
        for (int i = 0; i < NRET; i++) begin
            w_idx[i]  = r_head[TW-1:0] + TW'(i);
            w_done[i] = r_ent[w_idx[i]].alloc && !r_ent[w_idx[i]].pend_rd && !r_ent[w_idx[i]].pend_mem;
            w_norm[i] = r_ent[w_idx[i]].d;
            w_norm[i].rd_wdata = (w_norm[i].rd_addr == '0) ? '0 : w_norm[i].rd_wdata;
        end
    end

    // new entry record; rd_wdata/mem_rdata start at zero so absent results read as zero
    always_comb begin
        w_new            = '0;
        w_new.d.insn     = a_insn;
        w_new.d.trap     = a_trap;
        w_new.d.intr     = a_intr;
        w_new.d.mode     = a_mode;
        w_new.d.pc_rdata = a_pc_rdata;
        w_new.d.pc_wdata = a_pc_wdata;
        w_new.d.rs1_addr = a_rs1_addr;
        w_new.d.rs2_addr = a_rs2_addr;
        w_new.d.rs1_rdata = a_rs1_rdata;
        w_new.d.rs2_rdata = a_rs2_rdata;
        w_new.d.rd_addr  = a_rd_pend ? a_rd_addr : '0;
        w_new.d.mem_addr = a_mem_addr;
        w_new.d.mem_rmask = a_mem_rmask;
        w_new.d.mem_wmask = a_mem_wmask;
        w_new.d.mem_wdata = a_mem_wdata;
        w_new.pend_rd    = a_rd_pend;
        w_new.pend_mem   = a_mem_pend;
        w_new.alloc      = 1'b1;
    end

    core_rvfi_retire_sel #(.NRET(NRET), .KW(KW)) u_sel (
        .i_done (w_done),
        .o_k    (w_k),
        .o_en   (w_en)
    );

    // entry storage: allocate at tail, apply legal writebacks, free retired entries
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_err  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
        end else begin
            for (int i = 0; i < NRET; i++) if (w_en[i]) r_ent[w_idx[i]].alloc <= 1'b0;
            r_head <= r_head + (TW+1)'(w_k);
            if (w_alloc) begin
                r_ent[a_tag] <= w_new;
                r_tail <= r_tail + 1'b1;
            end
            if (w_valid && !w_werr) begin
                r_ent[w_tag].d.rd_wdata <= w_rd_wdata;
                r_ent[w_tag].pend_rd    <= 1'b0;
            end
            if (m_valid && !w_merr) begin
                r_ent[m_tag].d.mem_rdata <= m_rdata;
                r_ent[m_tag].pend_mem    <= 1'b0;
            end
            if (w_werr || w_merr) r_err <= 1'b1;
        end
    end

    // registered RVFI lanes; lanes not retiring keep their previous data
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_valid <= '0;
            r_order <= '0;
            for (int i = 0; i < NRET; i++) begin
                r_lane[i] <= '0;
                r_ord[i]  <= '0;
            end
        end else begin
            r_valid <= w_en;
            r_order <= r_order + ORDER_W'(w_k);
            for (int i = 0; i < NRET; i++) begin
                if (w_en[i]) begin
                    r_lane[i] <= w_norm[i];
                    r_ord[i]  <= r_order + ORDER_W'(i);
                end
            end
        end
    end

    for (genvar g = 0; g < NRET; g++) begin : g_lane
        assign rvfi_order[g*64 +: 64]          = r_ord[g];
        assign rvfi_insn[g*ILEN +: ILEN]       = r_lane[g].insn;
        assign rvfi_trap[g]                    = r_lane[g].trap;
        assign rvfi_intr[g]                    = r_lane[g].intr;
        assign rvfi_mode[g*2 +: 2]             = r_lane[g].mode;
        assign rvfi_rs1_addr[g*5 +: 5]         = r_lane[g].rs1_addr;
        assign rvfi_rs2_addr[g*5 +: 5]         = r_lane[g].rs2_addr;
        assign rvfi_rs1_rdata[g*XLEN +: XLEN]  = r_lane[g].rs1_rdata;
        assign rvfi_rs2_rdata[g*XLEN +: XLEN]  = r_lane[g].rs2_rdata;
        assign rvfi_rd_addr[g*5 +: 5]          = r_lane[g].rd_addr;
        assign rvfi_rd_wdata[g*XLEN +: XLEN]   = r_lane[g].rd_wdata;
        assign rvfi_pc_rdata[g*XLEN +: XLEN]   = r_lane[g].pc_rdata;
        assign rvfi_pc_wdata[g*XLEN +: XLEN]   = r_lane[g].pc_wdata;
        assign rvfi_mem_addr[g*XLEN +: XLEN]   = r_lane[g].mem_addr;
        assign rvfi_mem_rmask[g*(XLEN/8) +: XLEN/8] = r_lane[g].mem_rmask;
        assign rvfi_mem_wmask[g*(XLEN/8) +: XLEN/8] = r_lane[g].mem_wmask;
        assign rvfi_mem_rdata[g*XLEN +: XLEN]  = r_lane[g].mem_rdata;
        assign rvfi_mem_wdata[g*XLEN +: XLEN]  = r_lane[g].mem_wdata;
    end

endmodule
